hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core. It replaces the purely combinational hazard unit. It adds zero-register filtering, branch-in-ID operand stalls on ALU results, a multi-cycle mult/div busy tracker, multi-slot wrong-path flushing, and saturating stall/flush performance counters. It sits beside the IF/ID and ID/EX registers and drives PC write-enable, IF/ID write-enable, ID/EX bubble insertion and IF/ID flush.

Parameters:
REG_AW, 5, register-address width
FLUSH_SLOTS, 1, wrong-path fetch slots squashed per redirect (legal 1..3)
MD_CYCLES, 32, busy cycles of mult/div unit after issue (legal 1..255)
CNT_W, 16, perf counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
id_ex_mem_read  in  1  instr in EX is a load
id_ex_reg_write  in  1  instr in EX writes a register
id_ex_dst  in  REG_AW  destination reg of EX instr (rd/rt already muxed)
ex_mem_mem_read  in  1  instr in MEM is a load
ex_mem_dst  in  REG_AW  destination reg of MEM instr
if_id_rs  in  REG_AW  rs of instr in ID
if_id_rt  in  REG_AW  rt of instr in ID
if_id_uses_rt  in  1  ID instr reads rt as a source
if_id_uses_hilo  in  1  ID instr is mfhi/mflo or mult/div
br  in  1  ID instr is a conditional branch
br_taken  in  1  ID comparator result
jump  in  1  ID instr is j/jal/jr
md_start  in  1  mult/div issued from EX this cycle
pc_wr_en  out  1  PC update enable
if_id_wr_en  out  1  IF/ID load enable
nop_flag  out  1  insert bubble into ID/EX
flush_flag  out  1  clear IF/ID (squash fetched instr)
md_busy  out  1  mult/div unit busy
stall_count  out  CNT_W  cycles with pc_wr_en=0
flush_count  out  CNT_W  redirect events

Behaviour:
- Hazard outputs are combinational from the inputs plus registered state: 0-cycle detection latency. md_cnt, flush_rem and the perf counters are registered.
- Reset (rst_n=0 at clk edge): md_cnt=0, flush_rem=0, stall_count=0, flush_count=0.
- While rst_n=0 the outputs are forced: pc_wr_en=0, if_id_wr_en=0, nop_flag=1, flush_flag=1, md_busy=0.
- Source match m(r) = (r!=0) and (r==if_id_rs or (if_id_uses_rt and r==if_id_rt)). Register 0 never creates a hazard.
- load_haz = id_ex_mem_read & m(id_ex_dst).
- br_haz = (br|jump) & ((id_ex_reg_write & m(id_ex_dst)) | (ex_mem_mem_read & m(ex_mem_dst))). The jr operand is covered by the same rule.
- md_haz = if_id_uses_hilo & md_busy.
- md_cnt: md_start loads MD_CYCLES. Otherwise it decrements when nonzero. md_busy = (md_cnt!=0). md_start while busy reloads the counter (restart).
- Priority per cycle:
  1. flush_rem>0: flush_flag=1, pc_wr_en=1, if_id_wr_en=1, nop_flag=0. All hazards are ignored because IF/ID holds a wrong-path instr. flush_rem decrements.
  2. load_haz|br_haz|md_haz: STALL. pc_wr_en=0, if_id_wr_en=0, nop_flag=1, flush_flag=0.
  3. (br&br_taken)|jump: REDIRECT. pc_wr_en=1, if_id_wr_en=1, nop_flag=0, flush_flag=1. flush_rem loads FLUSH_SLOTS-1. flush_count increments.
  4. Otherwise: pc_wr_en=1, if_id_wr_en=1, nop_flag=0, flush_flag=0.
- A not-taken branch with no hazard is handled as normal (4).
- A branch stalled by br_haz redirects only on the cycle the hazard clears.
- A stalled cycle increments stall_count. Both counters saturate at all-ones and never wrap.
- Simultaneous events:
  - md_start in the same cycle as an md_haz evaluation: the stall decision uses the pre-edge md_cnt.
  - md_start during a flush still loads md_cnt.
- Reset mid-stall or mid-flush: the state clears on that edge. Normal operation resumes on the first cycle with rst_n=1.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_dst=8, if_id_rs=8 -> exactly 1 cycle of pc_wr_en=0, if_id_wr_en=0, nop_flag=1; stall_count=1. Same test with dst=0 -> no stall.
- uses_rt filter: id_ex_dst=9, if_id_rt=9, if_id_uses_rt=0 -> no stall. With if_id_uses_rt=1 -> stall.
- Branch on ALU result: br=1, br_taken=1, id_ex_reg_write=1, id_ex_dst=rs -> 1 stall cycle, then REDIRECT with flush_flag=1; flush_count=1.
- FLUSH_SLOTS=3, jump=1 -> flush_flag high for 3 consecutive cycles. A load_haz presented in cycle 2 is ignored. pc_wr_en stays 1 throughout.
- MD_CYCLES=4: md_start pulse, then mfhi held in ID -> md_busy high 4 cycles; stall for 4 cycles; release on the 5th.
- Saturation/reset: CNT_W=4 with 20 stall cycles -> stall_count=15. rst_n=0 mid-flush -> flush_flag forced 1 during reset, flush_rem=0 and counters 0 after release.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use, branch operand,
// mult/div busy stalls, multi-slot wrong-path flushing and saturating perf counters.
module hazard_ctrl_unit #(
    parameter int REG_AW      = 5,
    parameter int FLUSH_SLOTS = 1,
    parameter int MD_CYCLES   = 32,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_reg_write,
    input  logic [REG_AW-1:0] id_ex_dst,
    input  logic              ex_mem_mem_read,
    input  logic [REG_AW-1:0] ex_mem_dst,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              if_id_uses_hilo,
    input  logic              br,
    input  logic              br_taken,
    input  logic              jump,
    input  logic              md_start,
    output logic              pc_wr_en,
    output logic              if_id_wr_en,
    output logic              nop_flag,
    output logic              flush_flag,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int MD_W = $clog2(MD_CYCLES + 1);

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_FLUSH,
        ACT_STALL,
        ACT_REDIRECT
    } act_e;

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [1:0]       flush_rem_q, flush_rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic busy;
    logic load_haz, br_haz, md_haz;
    act_e act;

    // Register 0 is hardwired to zero, so it can never be a true dependency.
    function automatic logic src_match(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rt,
                                       input logic              uses_rt);
        return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign busy = (md_cnt_q != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        load_haz    = id_ex_mem_read & src_match(id_ex_dst, if_id_rs, if_id_rt, if_id_uses_rt);
        br_haz      = (br | jump) &
                      ((id_ex_reg_write & src_match(id_ex_dst, if_id_rs, if_id_rt, if_id_uses_rt)) |
                       (ex_mem_mem_read & src_match(ex_mem_dst, if_id_rs, if_id_rt, if_id_uses_rt)));
        md_haz      = if_id_uses_hilo & busy;

        act = ACT_RUN;
        if (flush_rem_q != '0)
            act = ACT_FLUSH;
        else if (load_haz | br_haz | md_haz)
            act = ACT_STALL;
        else if ((br & br_taken) | jump)
            act = ACT_REDIRECT;

        pc_wr_en    = 1'b1;
        if_id_wr_en = 1'b1;
        nop_flag    = 1'b0;
        flush_flag  = 1'b0;
        md_busy     = busy;
        md_cnt_d    = md_cnt_q;
        flush_rem_d = flush_rem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (act)
            ACT_FLUSH: begin
                flush_flag  = 1'b1;
                flush_rem_d = flush_rem_q - 2'd1;
            end
            ACT_STALL: begin
                pc_wr_en    = 1'b0;
                if_id_wr_en = 1'b0;
                nop_flag    = 1'b1;
                if (stall_cnt_q != '1)
                    stall_cnt_d = stall_cnt_q + 1'b1;
            end
            ACT_REDIRECT: begin
                flush_flag  = 1'b1;
                flush_rem_d = 2'(FLUSH_SLOTS - 1);
                if (flush_cnt_q != '1)
                    flush_cnt_d = flush_cnt_q + 1'b1;
            end
            default: ;
        endcase

        // A new issue restarts the busy window even if the unit is still busy.
        if (md_start)
            md_cnt_d = MD_W'(MD_CYCLES);
        else if (busy)
            md_cnt_d = md_cnt_q - 1'b1;

        if (!rst_n) begin
            pc_wr_en    = 1'b0;
            if_id_wr_en = 1'b0;
            nop_flag    = 1'b1;
            flush_flag  = 1'b1;
            md_busy     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
        if (!rst_n) begin
            md_cnt_q    <= '0;
            flush_rem_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            flush_rem_q <= flush_rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with FLUSH_SLOTS=3, MD_CYCLES=4, CNT_W=4;
// control outputs are compared as {pc_wr_en, if_id_wr_en, nop_flag, flush_flag}.
module tb_hazard_ctrl_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0010;
    localparam logic [3:0] C_FLUSH = 4'b1101;
    localparam logic [3:0] C_RST   = 4'b0011;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic [REG_AW-1:0] id_ex_dst, ex_mem_dst, if_id_rs, if_id_rt;
    logic              if_id_uses_rt, if_id_uses_hilo, br, br_taken, jump, md_start;
    logic              pc_wr_en, if_id_wr_en, nop_flag, flush_flag, md_busy;
    logic [CNT_W-1:0]  stall_count, flush_count;
    logic [3:0]        ctl;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl_unit #(
        .REG_AW(REG_AW), .FLUSH_SLOTS(3), .MD_CYCLES(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_dst(id_ex_dst), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dst(ex_mem_dst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_uses_hilo(if_id_uses_hilo), .br(br), .br_taken(br_taken), .jump(jump),
        .md_start(md_start), .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en),
        .nop_flag(nop_flag), .flush_flag(flush_flag), .md_busy(md_busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_wr_en, if_id_wr_en, nop_flag, flush_flag};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_dst = '0;
        ex_mem_mem_read = 0; ex_mem_dst = '0;
        if_id_rs = '0; if_id_rt = '0; if_id_uses_rt = 0; if_id_uses_hilo = 0;
        br = 0; br_taken = 0; jump = 0; md_start = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick(); tick();
        mid();
        check("reset_ctl", 8'(ctl), 8'(C_RST));
        check("reset_busy", 8'(md_busy), 8'd0);
        tick();
        rst_n = 1'b1;
        mid();
        check("idle_ctl", 8'(ctl), 8'(C_RUN));
        check("idle_stall_cnt", 8'(stall_count), 8'd0);
        check("idle_flush_cnt", 8'(flush_count), 8'd0);

        // Load-use on rs, then the same load targeting r0.
        tick();
        id_ex_mem_read = 1; id_ex_dst = 5'd8; if_id_rs = 5'd8;
        mid(); check("loaduse_stall", 8'(ctl), 8'(C_STALL));
        tick();
        clear_inputs();
        mid(); check("loaduse_release", 8'(ctl), 8'(C_RUN));
        check("loaduse_cnt", 8'(stall_count), 8'd1);
        tick();
        id_ex_mem_read = 1; id_ex_dst = 5'd0; if_id_rs = 5'd0;
        mid(); check("r0_no_stall", 8'(ctl), 8'(C_RUN));
        tick();
        check("r0_cnt", 8'(stall_count), 8'd1);

        // rt only matters when the ID instruction actually reads it.
        clear_inputs();
        id_ex_mem_read = 1; id_ex_dst = 5'd9; if_id_rt = 5'd9; if_id_rs = 5'd3;
        mid(); check("rt_unused", 8'(ctl), 8'(C_RUN));
        if_id_uses_rt = 1;
        #1; check("rt_used", 8'(ctl), 8'(C_STALL));
        tick();
        clear_inputs();
        mid(); check("rt_cnt", 8'(stall_count), 8'd2);

        // Taken branch on an ALU result: stall once, then redirect + 2 flush slots.
        tick();
        br = 1; br_taken = 1; id_ex_reg_write = 1; id_ex_dst = 5'd5; if_id_rs = 5'd5;
        mid(); check("br_alu_stall", 8'(ctl), 8'(C_STALL));
        tick();
        id_ex_reg_write = 0;
        mid(); check("br_redirect", 8'(ctl), 8'(C_FLUSH));
        check("br_stall_cnt", 8'(stall_count), 8'd3);
        tick();
        clear_inputs();
        mid(); check("br_flush1", 8'(ctl), 8'(C_FLUSH));
        check("br_flush_cnt", 8'(flush_count), 8'd1);
        tick();
        mid(); check("br_flush2", 8'(ctl), 8'(C_FLUSH));
        tick();
        mid(); check("br_done", 8'(ctl), 8'(C_RUN));

        // jr waiting on a load in MEM, then a load hazard arrives during the flush slots.
        tick();
        jump = 1; ex_mem_mem_read = 1; ex_mem_dst = 5'd7; if_id_rs = 5'd7;
        mid(); check("jr_mem_stall", 8'(ctl), 8'(C_STALL));
        tick();
        ex_mem_mem_read = 0;
        mid(); check("jr_redirect", 8'(ctl), 8'(C_FLUSH));
        tick();
        clear_inputs();
        id_ex_mem_read = 1; id_ex_dst = 5'd8; if_id_rs = 5'd8;
        mid(); check("flush_ignores_haz1", 8'(ctl), 8'(C_FLUSH));
        check("jr_flush_cnt", 8'(flush_count), 8'd2);
        tick();
        mid(); check("flush_ignores_haz2", 8'(ctl), 8'(C_FLUSH));
        tick();
        mid(); check("post_flush_stall", 8'(ctl), 8'(C_STALL));
        check("flush_no_stall_cnt", 8'(stall_count), 8'd4);
        tick();
        clear_inputs();
        mid(); check("post_flush_cnt", 8'(stall_count), 8'd5);

        // mult/div: issue alongside mfhi (pre-edge counter is 0), then 4 busy stalls.
        tick();
        md_start = 1; if_id_uses_hilo = 1;
        mid(); check("md_issue_no_stall", 8'(ctl), 8'(C_RUN));
        tick();
        md_start = 0;
        for (int i = 0; i < 4; i++) begin
            mid();
            check($sformatf("md_busy_%0d", i), 8'(md_busy), 8'd1);
            check($sformatf("md_stall_%0d", i), 8'(ctl), 8'(C_STALL));
            tick();
        end
        mid();
        check("md_idle", 8'(md_busy), 8'd0);
        check("md_release", 8'(ctl), 8'(C_RUN));
        check("md_stall_cnt", 8'(stall_count), 8'd9);

        // 20 more stall cycles: 9 + 20 saturates at 15.
        tick();
        clear_inputs();
        id_ex_mem_read = 1; id_ex_dst = 5'd12; if_id_rs = 5'd12;
        for (int i = 0; i < 20; i++) tick();
        clear_inputs();
        mid(); check("stall_saturate", 8'(stall_count), 8'd15);

        // md_start during a flush slot still loads the busy counter.
        tick();
        jump = 1;
        mid(); check("j_redirect", 8'(ctl), 8'(C_FLUSH));
        tick();
        clear_inputs();
        md_start = 1;
        mid(); check("md_in_flush_ctl", 8'(ctl), 8'(C_FLUSH));
        tick();
        md_start = 0;
        mid(); check("md_in_flush_busy", 8'(md_busy), 8'd1);
        check("md_in_flush_ctl2", 8'(ctl), 8'(C_FLUSH));

        // Reset in the middle of a flush with the mult/div still busy.
        tick();
        jump = 1;
        mid(); check("j2_redirect", 8'(ctl), 8'(C_FLUSH));
        tick();
        clear_inputs();
        rst_n = 0;
        mid(); check("rst_mid_flush_ctl", 8'(ctl), 8'(C_RST));
        check("rst_mid_busy", 8'(md_busy), 8'd0);
        tick();
        rst_n = 1;
        mid();
        check("rst_release_ctl", 8'(ctl), 8'(C_RUN));
        check("rst_release_busy", 8'(md_busy), 8'd0);
        check("rst_release_stall", 8'(stall_count), 8'd0);
        check("rst_release_flush", 8'(flush_count), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
